pop_counter_bank: RTL and testbench
===================================

Name: pop_counter_bank

Overview:
Parametrised bank of per-channel pop counters for the FIFO-output stage. Each channel counts successful pops, where a successful pop is pop asserted while the FIFO is non-empty. Counters are read one at a time through a req/idx handshake, gated by the system idle indication. Adds configurable channel count and width, saturate/wrap mode, sticky overflow flags, clear-on-read, global clear and an out-of-range error flag.

Parameters:
NUM_CH, 4, number of counted channels (1..16)
CNT_W, 5, counter width in bits
IDX_W, 2, width of idx; must satisfy 2**IDX_W >= NUM_CH
SATURATE, 1, 1 = hold at all-ones on overflow; 0 = wrap to 0
CLEAR_ON_READ, 0, 1 = clear the addressed counter and its overflow flag when it is read

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
pop  in  NUM_CH  per-channel FIFO pop strobe
empty  in  NUM_CH  per-channel FIFO empty flag
idle  in  1  system idle; reads accepted only while high
req  in  1  read request, level
idx  in  IDX_W  channel to read
clr_all  in  1  synchronous clear of all counters and flags
rd_valid  out  1  one-cycle pulse; rd_data, rd_ovf and rd_err are valid
rd_data  out  CNT_W  counter value
rd_ovf  out  1  sticky overflow flag of the addressed channel
rd_err  out  1  idx >= NUM_CH

Behaviour:
- Reset (reset=1 at a clk edge): all counters = 0, overflow flags = 0, rd_valid = 0, rd_data = 0, rd_ovf = 0, rd_err = 0, FSM = S_WAIT. Reset overrides every other input, including in the middle of a read.
- Event per channel: ev[i] = pop[i] & ~empty[i]. Any number of channels can count in the same cycle, independently.
- On ev[i], cnt[i] increments by 1.
- At all-ones with SATURATE=1: cnt[i] holds at all-ones and ovf[i] is set.
- At all-ones with SATURATE=0: cnt[i] wraps to 0 and ovf[i] is set.
- ovf[i] stays set until reset, clr_all, or a clear-on-read of channel i.
- Counting continues whether idle is high or low.
- clr_all: all counters and flags go to 0 on the next edge. An ev in the same cycle is discarded. clr_all has priority over a read in the same cycle; that read is dropped and rd_valid stays 0.
- Read FSM:
  - S_WAIT: when req & idle & ~clr_all, capture the value on the next edge, pulse rd_valid=1 for exactly one cycle (latency 1), and go to S_HOLD.
  - S_HOLD: rd_valid=0; stay until req=0, then return to S_WAIT. A held req gives a single response; a new read needs req to drop and re-assert.
  - If idle falls while in S_HOLD, the FSM still waits in S_HOLD for req=0.
- Captured value is the pre-edge cnt[idx] and ovf[idx]. An event on the same channel in the capture cycle is not included in the returned value, but is still counted internally.
- rd_data, rd_ovf and rd_err hold their value until the next capture.
- CLEAR_ON_READ=1: on the capture edge, cnt[idx] loads ev[idx] (0 or 1) and ovf[idx] clears. Events are never lost.
- idx >= NUM_CH: rd_valid pulses with rd_err=1, rd_data=0 and rd_ovf=0; no counter is modified.
- req while idle=0: ignored; the FSM stays in S_WAIT and the request is not remembered.

Test Plan:
- Count and read: NUM_CH=4, CNT_W=5. Pop ch2 7 times with empty=0, plus 3 pops on ch2 with empty[2]=1. Then idle=1, req=1, idx=2 → one cycle later rd_valid=1, rd_data=7, rd_ovf=0, rd_err=0. rd_valid=0 for the following cycles while req stays high.
- Saturation: SATURATE=1, 40 pops on ch0 → rd_data=31, rd_ovf=1. Same stimulus with SATURATE=0 → rd_data=8 (40 mod 32), rd_ovf=1.
- Simultaneous events: all 4 channels pop in the same 10 cycles → each channel reads 10. Also read ch1 while ch1 pops in the capture cycle, with cnt[1]=10 before the edge → returned 10; a second read returns 11.
- Clear-on-read: CLEAR_ON_READ=1, ch3=5, read ch3 → returns 5; an immediate re-read returns 0. Clear-on-read with a pop in the capture cycle → re-read returns 1.
- Gating and errors:
  - req with idle=0 → no rd_valid.
  - NUM_CH=3, IDX_W=2, idx=3 → rd_err=1, rd_data=0.
  - clr_all and req in the same cycle → no rd_valid, and all counters read 0 afterwards.
- Reset mid-operation: assert reset while in S_HOLD with counters non-zero → all outputs 0, FSM in S_WAIT, the next read returns 0.

Source files
------------

// File: rtl/pop_counter_bank.sv
// Bank of per-channel pop counters with a one-at-a-time read port.
// Reads are gated by idle and answered with a single-cycle rd_valid pulse.
module pop_counter_bank #(
   parameter int NUM_CH        = 4,
   parameter int CNT_W         = 5,
   parameter int IDX_W         = 2,
   parameter bit SATURATE      = 1'b1,
   parameter bit CLEAR_ON_READ = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [NUM_CH-1:0] pop,
   input  logic [NUM_CH-1:0] empty,
   input  logic              idle,
   input  logic              req,
   input  logic [IDX_W-1:0]  idx,
   input  logic              clr_all,
   output logic              rd_valid,
   output logic [CNT_W-1:0]  rd_data,
   output logic              rd_ovf,
   output logic              rd_err
);

   typedef enum logic {S_WAIT, S_HOLD} state_t;

   localparam logic [IDX_W:0] NUM_CH_L = (IDX_W + 1)'(NUM_CH);

   state_t            state, state_nxt;
   logic              capture;
   logic              idx_ok;
   logic [NUM_CH-1:0] ev;
   logic [CNT_W-1:0]  cnt [NUM_CH];
   logic [NUM_CH-1:0] ovf;
   logic [CNT_W-1:0]  sel_cnt;
   logic              sel_ovf;

   assign ev     = pop & ~empty;
   assign idx_ok = {1'b0, idx} < NUM_CH_L;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      sel_cnt = '0;
      sel_ovf = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (idx == IDX_W'(i)) begin
            sel_cnt = cnt[i];
            sel_ovf = ovf[i];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      unique case (state)
         S_WAIT: begin
            if (req && idle && !clr_all) begin
               capture   = 1'b1;
               state_nxt = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!req) state_nxt = S_WAIT;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) state <= S_WAIT;
      else       state <= state_nxt;
   end

   // NOTE: the counter array is reset explicitly; a read right after reset must return zero.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (reset || clr_all) begin
            cnt[i] <= '0;
            ovf[i] <= 1'b0;
         end else if (CLEAR_ON_READ && capture && idx == IDX_W'(i)) begin
            // A pop landing in the read cycle becomes the fresh count, so it is not lost.
            cnt[i] <= CNT_W'(ev[i]);
            ovf[i] <= 1'b0;
         end else if (ev[i]) begin
            if (&cnt[i]) begin
               ovf[i] <= 1'b1;
               if (!SATURATE) cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_ovf   <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= capture;
         if (capture) begin
            rd_data <= idx_ok ? sel_cnt : '0;
            rd_ovf  <= idx_ok & sel_ovf;
            rd_err  <= ~idx_ok;
         end
      end
   end

endmodule

// File: tb/tb_pop_counter_bank.sv
// Self-checking bench for pop_counter_bank: four parameter variants, with a
// scoreboard of expected read responses consumed by a negedge monitor.
module tb_pop_counter_bank;

   typedef struct {
      int         d;
      logic [4:0] data;
      logic       ovf;
      logic       err;
   } exp_t;

   logic       clk;
   logic       reset;
   logic [3:0] pop      [4];
   logic [3:0] empty    [4];
   logic       idle     [4];
   logic       req      [4];
   logic [1:0] idx      [4];
   logic       clr_all  [4];
   logic       rd_valid [4];
   logic [4:0] rd_data  [4];
   logic       rd_ovf   [4];
   logic       rd_err   [4];

   exp_t sbq[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   // 0: saturating, 1: wrapping, 2: clear-on-read, 3: three channels
   pop_counter_bank #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1'b1), .CLEAR_ON_READ(1'b0)) dut_sat (
      .clk(clk), .reset(reset), .pop(pop[0]), .empty(empty[0]), .idle(idle[0]), .req(req[0]),
      .idx(idx[0]), .clr_all(clr_all[0]), .rd_valid(rd_valid[0]), .rd_data(rd_data[0]),
      .rd_ovf(rd_ovf[0]), .rd_err(rd_err[0]));
   pop_counter_bank #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1'b0), .CLEAR_ON_READ(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .pop(pop[1]), .empty(empty[1]), .idle(idle[1]), .req(req[1]),
      .idx(idx[1]), .clr_all(clr_all[1]), .rd_valid(rd_valid[1]), .rd_data(rd_data[1]),
      .rd_ovf(rd_ovf[1]), .rd_err(rd_err[1]));
   pop_counter_bank #(.NUM_CH(4), .CNT_W(5), .IDX_W(2), .SATURATE(1'b1), .CLEAR_ON_READ(1'b1)) dut_cor (
      .clk(clk), .reset(reset), .pop(pop[2]), .empty(empty[2]), .idle(idle[2]), .req(req[2]),
      .idx(idx[2]), .clr_all(clr_all[2]), .rd_valid(rd_valid[2]), .rd_data(rd_data[2]),
      .rd_ovf(rd_ovf[2]), .rd_err(rd_err[2]));
   pop_counter_bank #(.NUM_CH(3), .CNT_W(5), .IDX_W(2), .SATURATE(1'b1), .CLEAR_ON_READ(1'b0)) dut_n3 (
      .clk(clk), .reset(reset), .pop(pop[3][2:0]), .empty(empty[3][2:0]), .idle(idle[3]), .req(req[3]),
      .idx(idx[3]), .clr_all(clr_all[3]), .rd_valid(rd_valid[3]), .rd_data(rd_data[3]),
      .rd_ovf(rd_ovf[3]), .rd_err(rd_err[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Every rd_valid pulse must match the oldest pending expectation.
   always @(negedge clk) begin
      for (int d = 0; d < 4; d++) begin
         if (rd_valid[d] === 1'b1) begin
            n_checks++;
            if (sbq.size() == 0) begin
               $display("FAIL unexpected_rd_valid dut%0d: rd_valid=1, required no response", d);
            end else begin
               mon_e = sbq.pop_front();
               if (mon_e.d !== d || rd_data[d] !== mon_e.data || rd_ovf[d] !== mon_e.ovf ||
                   rd_err[d] !== mon_e.err)
                  $display("FAIL read_response dut%0d: data=%0d ovf=%0b err=%0b, required dut%0d data=%0d ovf=%0b err=%0b",
                           d, rd_data[d], rd_ovf[d], rd_err[d], mon_e.d, mon_e.data, mon_e.ovf, mon_e.err);
               else
                  n_pass++;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input int d, input logic [4:0] data, input logic ovf, input logic err);
      exp_t e;
      e.d = d; e.data = data; e.ovf = ovf; e.err = err;
      sbq.push_back(e);
   endtask

   task automatic check_valid(input int d, input logic want, input string name);
      n_checks++;
      if (rd_valid[d] !== want)
         $display("FAIL %s dut%0d: rd_valid=%0b, required %0b", name, d, rd_valid[d], want);
      else
         n_pass++;
   endtask

   task automatic pulse_pop(input int d, input logic [3:0] mask, input logic [3:0] emp, input int n);
      for (int k = 0; k < n; k++) begin
         pop[d] = mask; empty[d] = emp;
         step();
      end
      pop[d] = '0; empty[d] = '0;
   endtask

   task automatic clear_bank(input int d);
      clr_all[d] = 1'b1;
      step();
      clr_all[d] = 1'b0;
   endtask

   // Full handshake; cap_pop is driven only during the capture cycle.
   task automatic do_read(input int d, input logic [1:0] ch, input logic [3:0] cap_pop,
                          input logic [4:0] exp_data, input logic exp_ovf, input logic exp_err,
                          input string name);
      push_exp(d, exp_data, exp_ovf, exp_err);
      idle[d] = 1'b1; req[d] = 1'b1; idx[d] = ch; pop[d] = cap_pop;
      step();
      pop[d] = '0;
      check_valid(d, 1'b1, name);
      for (int k = 0; k < 2; k++) begin
         step();
         check_valid(d, 1'b0, {name, "_single"});
      end
      req[d] = 1'b0;
      step();
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      step();
      for (int d = 0; d < 4; d++) begin
         n_checks++;
         if ({rd_valid[d], rd_data[d], rd_ovf[d], rd_err[d]} !== 8'h00)
            $display("FAIL reset_outputs dut%0d: valid=%0b data=%0d ovf=%0b err=%0b, required all 0",
                     d, rd_valid[d], rd_data[d], rd_ovf[d], rd_err[d]);
         else
            n_pass++;
      end
   endtask

   task automatic test_count_read();
      pulse_pop(0, 4'b0100, 4'b0000, 7);
      pulse_pop(0, 4'b0100, 4'b0100, 3);
      do_read(0, 2'd2, 4'b0000, 5'd7, 1'b0, 1'b0, "count_read");
   endtask

   task automatic test_saturation();
      pulse_pop(0, 4'b0001, 4'b0000, 40);
      do_read(0, 2'd0, 4'b0000, 5'd31, 1'b1, 1'b0, "saturate");
      pulse_pop(1, 4'b0001, 4'b0000, 40);
      do_read(1, 2'd0, 4'b0000, 5'd8, 1'b1, 1'b0, "wrap");
   endtask

   task automatic test_simultaneous();
      clear_bank(0);
      pulse_pop(0, 4'b1111, 4'b0000, 10);
      do_read(0, 2'd0, 4'b0000, 5'd10, 1'b0, 1'b0, "simul_ch0");
      do_read(0, 2'd1, 4'b0010, 5'd10, 1'b0, 1'b0, "capture_pop_ch1");
      do_read(0, 2'd1, 4'b0000, 5'd11, 1'b0, 1'b0, "after_capture_ch1");
      do_read(0, 2'd2, 4'b0000, 5'd10, 1'b0, 1'b0, "simul_ch2");
      do_read(0, 2'd3, 4'b0000, 5'd10, 1'b0, 1'b0, "simul_ch3");
   endtask

   task automatic test_clear_on_read();
      pulse_pop(2, 4'b1000, 4'b0000, 5);
      do_read(2, 2'd3, 4'b0000, 5'd5, 1'b0, 1'b0, "cor_first");
      do_read(2, 2'd3, 4'b0000, 5'd0, 1'b0, 1'b0, "cor_reread");
      pulse_pop(2, 4'b1000, 4'b0000, 2);
      do_read(2, 2'd3, 4'b1000, 5'd2, 1'b0, 1'b0, "cor_capture_pop");
      do_read(2, 2'd3, 4'b0000, 5'd1, 1'b0, 1'b0, "cor_kept_pop");
      pulse_pop(2, 4'b0001, 4'b0000, 33);
      do_read(2, 2'd0, 4'b0000, 5'd31, 1'b1, 1'b0, "cor_ovf");
      do_read(2, 2'd0, 4'b0000, 5'd0, 1'b0, 1'b0, "cor_ovf_cleared");
   endtask

   task automatic test_out_of_range();
      pulse_pop(3, 4'b0111, 4'b0000, 4);
      do_read(3, 2'd3, 4'b0000, 5'd0, 1'b0, 1'b1, "idx_error");
      do_read(3, 2'd2, 4'b0000, 5'd4, 1'b0, 1'b0, "idx_error_ch2_intact");
      do_read(3, 2'd0, 4'b0000, 5'd4, 1'b0, 1'b0, "idx_error_ch0_intact");
   endtask

   task automatic test_gating();
      clear_bank(0);
      pulse_pop(0, 4'b0001, 4'b0000, 3);
      idle[0] = 1'b0; req[0] = 1'b1; idx[0] = 2'd0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_valid(0, 1'b0, "idle_low_ignored");
      end
      req[0] = 1'b0;
      step();
      idle[0] = 1'b1;
      step();
      check_valid(0, 1'b0, "idle_request_forgotten");
      do_read(0, 2'd0, 4'b0000, 5'd3, 1'b0, 1'b0, "read_after_gate");
      // Idle dropping and returning while req stays high must not retrigger.
      push_exp(0, 5'd3, 1'b0, 1'b0);
      req[0] = 1'b1;
      step();
      check_valid(0, 1'b1, "hold_idle_read");
      idle[0] = 1'b0;
      step();
      check_valid(0, 1'b0, "hold_idle_low");
      idle[0] = 1'b1;
      step();
      check_valid(0, 1'b0, "hold_idle_back");
      req[0] = 1'b0;
      step();
      step();
   endtask

   task automatic test_clr_collision();
      pop[0] = 4'b0001; clr_all[0] = 1'b1; req[0] = 1'b1; idle[0] = 1'b1; idx[0] = 2'd0;
      step();
      pop[0] = '0; clr_all[0] = 1'b0; req[0] = 1'b0;
      check_valid(0, 1'b0, "clr_drops_read");
      step();
      check_valid(0, 1'b0, "clr_no_late_read");
      for (int ch = 0; ch < 4; ch++)
         do_read(0, 2'(ch), 4'b0000, 5'd0, 1'b0, 1'b0, "after_clr_all");
   endtask

   task automatic test_reset_mid();
      pulse_pop(0, 4'b0010, 4'b0000, 5);
      push_exp(0, 5'd5, 1'b0, 1'b0);
      idle[0] = 1'b1; req[0] = 1'b1; idx[0] = 2'd1;
      step();
      check_valid(0, 1'b1, "pre_reset_read");
      reset = 1'b1;
      step();
      n_checks++;
      if ({rd_valid[0], rd_data[0], rd_ovf[0], rd_err[0]} !== 8'h00)
         $display("FAIL reset_mid_outputs: valid=%0b data=%0d ovf=%0b err=%0b, required all 0",
                  rd_valid[0], rd_data[0], rd_ovf[0], rd_err[0]);
      else
         n_pass++;
      // req is still high: a bank back in S_WAIT answers on the first edge after reset.
      push_exp(0, 5'd0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      check_valid(0, 1'b1, "post_reset_read");
      req[0] = 1'b0;
      step();
      step();
   endtask

   initial begin
      reset = 1'b1;
      for (int d = 0; d < 4; d++) begin
         pop[d] = '0; empty[d] = '0; idle[d] = 1'b1; req[d] = 1'b0; idx[d] = '0; clr_all[d] = 1'b0;
      end
      test_reset();
      test_count_read();
      test_saturation();
      test_simultaneous();
      test_clear_on_read();
      test_out_of_range();
      test_gating();
      test_clr_collision();
      test_reset_mid();
      n_checks++;
      if (sbq.size() != 0)
         $display("FAIL responses_outstanding: %0d pending, required 0", sbq.size());
      else
         n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
